// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam int XLEN = 32;

  // Access size encodings on req_size
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RMW_RD = ST_RMW_RD,
    WRITE  = ST_WRITE,
    RESP   = ST_RESP
  } state_t;

  // Illegal size, misaligned half/word, or word index past the end of memory
  function automatic logic access_error(input logic [1:0] size,
                                        input logic [XLEN-1:0] addr,
                                        input int unsigned depth);
    logic bad;
    bad = (size == SIZE_ILL)
        | ((size == SIZE_HALF) & addr[0])
        | ((size == SIZE_WORD) & (addr[1:0] != 2'b00))
        | ({2'b00, addr[XLEN-1:2]} >= depth);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, extend it, and splice store data into the old word
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    rdata    = word;
    merged   = wdata;
    unique case (size)
      SIZE_BYTE: begin
        rdata  = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged = word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        rdata  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged = word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        rdata  = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-addressed requests to word-indexed data_memory,
// read-modify-write for sub-word stores, sign/zero-extended loads, error flagging.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_error,
  output logic             mem_write_read,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data
);

  state_t           state;
  logic [1:0]       lat_size;
  logic             lat_unsigned;
  logic [1:0]       lat_offset;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] lane_rdata;
  logic [WIDTH-1:0] lane_merged;
  logic             req_bad;

  // Ready only while idle and out of reset
  assign req_ready = (state == IDLE) & reset;
  assign req_bad   = access_error(req_size, req_addr, MEM_DEPTH);

  lsu_lane_align u_align (
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .offset      (lat_offset),
    .word        (mem_read_data),
    .wdata       (lat_wdata),
    .rdata       (lane_rdata),
    .merged      (lane_merged)
  );

  // Control FSM; memory-side and response outputs are registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lat_size       <= '0;
      lat_unsigned   <= 1'b0;
      lat_offset     <= '0;
      lat_wdata      <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_offset   <= req_addr[1:0];
            lat_wdata    <= req_wdata;
            if (req_bad) begin
              // no memory access on the error path
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write) begin
              state       <= LOAD;
              mem_address <= {2'b00, req_addr[WIDTH-1:2]};
            end else if (req_size == SIZE_WORD) begin
              state          <= WRITE;
              mem_write_read <= 1'b1;
              mem_address    <= {2'b00, req_addr[WIDTH-1:2]};
              mem_write_data <= req_wdata;
            end else begin
              state       <= RMW_RD;
              mem_address <= {2'b00, req_addr[WIDTH-1:2]};
            end
          end
        end
        LOAD: begin
          state       <= RESP;
          mem_address <= '0;
          resp_valid  <= 1'b1;
          resp_error  <= 1'b0;
          resp_rdata  <= lane_rdata;
        end
        RMW_RD: begin
          // address is held; the merged word goes out next cycle
          state          <= WRITE;
          mem_write_read <= 1'b1;
          mem_write_data <= lane_merged;
        end
        WRITE: begin
          state          <= RESP;
          mem_write_read <= 1'b0;
          mem_address    <= '0;
          mem_write_data <= '0;
          resp_valid     <= 1'b1;
          resp_error     <= 1'b0;
          resp_rdata     <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          resp_valid     <= 1'b0;
          mem_write_read <= 1'b0;
          mem_address    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error, mem_write_read;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [256];
  int          writes_total = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_write_read(mem_write_read),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // data_memory model: combinational read, returns 0 while writing
  assign mem_read_data = mem_write_read ? 32'h0 :
                         (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_read) begin
      mem[mem_address[7:0]] <= mem_write_data;
      writes_total <= writes_total + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl[16];

  // Issue one request from IDLE at a falling edge and check the whole transaction
  task automatic do_req(input vec_t v);
    int lat, wr_k;
    logic wr_seen;
    logic [31:0] wr_a, wr_d, rd, er;
    lat = 0; wr_k = 0; wr_seen = 1'b0; wr_a = 0; wr_d = 0; rd = 0; er = 0;
    req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    chk({v.name, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_write_read) begin
        wr_seen = 1'b1; wr_k = k; wr_a = mem_address; wr_d = mem_write_data;
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = {31'b0, resp_error};
        break;
      end
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " rdata"}, rd, v.rdata);
    chk({v.name, " error"}, er, {31'b0, v.err});
    chk({v.name, " wrote"}, {31'b0, wr_seen}, {31'b0, v.exp_wr});
    if (v.exp_wr) begin
      chk({v.name, " wr_cycle"}, wr_k, v.lat - 1);
      chk({v.name, " wr_addr"}, wr_a, {2'b00, v.addr[31:2]});
      chk({v.name, " wr_data"}, wr_d, v.exp_wdata);
    end
    @(negedge clk);
    chk({v.name, " pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    vec_t lv;
    int acc, pulses;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;

    //        name        wr size   uns addr     wdata        lat rdata         err ewr exp_wdata
    tbl[0]  = '{"sw10",   1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 2, 32'h0,        0, 1, 32'hDEADBEEF};
    tbl[1]  = '{"sb11",   1, 2'b00, 0, 32'h11,  32'h0000005A, 3, 32'h0,        0, 1, 32'hDEAD5AEF};
    tbl[2]  = '{"lb13s",  0, 2'b00, 0, 32'h13,  32'h0,        2, 32'hFFFFFFDE, 0, 0, 32'h0};
    tbl[3]  = '{"lb13u",  0, 2'b00, 1, 32'h13,  32'h0,        2, 32'h000000DE, 0, 0, 32'h0};
    tbl[4]  = '{"lh12s",  0, 2'b01, 0, 32'h12,  32'h0,        2, 32'hFFFFDEAD, 0, 0, 32'h0};
    tbl[5]  = '{"lw10",   0, 2'b10, 0, 32'h10,  32'h0,        2, 32'hDEAD5AEF, 0, 0, 32'h0};
    tbl[6]  = '{"lh10u",  0, 2'b01, 1, 32'h10,  32'h0,        2, 32'h00005AEF, 0, 0, 32'h0};
    tbl[7]  = '{"lb11s",  0, 2'b00, 0, 32'h11,  32'h0,        2, 32'h0000005A, 0, 0, 32'h0};
    tbl[8]  = '{"sh12",   1, 2'b01, 0, 32'h12,  32'hFFFF1234, 3, 32'h0,        0, 1, 32'h12345AEF};
    tbl[9]  = '{"lw10b",  0, 2'b10, 0, 32'h10,  32'h0,        2, 32'h12345AEF, 0, 0, 32'h0};
    tbl[10] = '{"eh11",   1, 2'b01, 0, 32'h11,  32'h1111,     1, 32'h0,        1, 0, 32'h0};
    tbl[11] = '{"ew12",   0, 2'b10, 0, 32'h12,  32'h0,        1, 32'h0,        1, 0, 32'h0};
    tbl[12] = '{"esz3",   1, 2'b11, 0, 32'h10,  32'h0BADBAD0, 1, 32'h0,        1, 0, 32'h0};
    tbl[13] = '{"ew400",  1, 2'b10, 0, 32'h400, 32'h0BADBAD0, 1, 32'h0,        1, 0, 32'h0};
    tbl[14] = '{"lw3fc",  0, 2'b10, 0, 32'h3FC, 32'h0,        2, 32'h0,        0, 0, 32'h0};
    tbl[15] = '{"lw10c",  0, 2'b10, 0, 32'h10,  32'h0,        2, 32'h12345AEF, 0, 0, 32'h0};

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_wr", {31'b0, mem_write_read}, 32'd0);
    chk("rst mem_addr", mem_address, 32'd0);
    chk("rst mem_wdata", mem_write_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) do_req(tbl[i]);

    // reset while a byte store is in its read phase: no write may land
    acc = writes_total;
    req_write = 1; req_size = 2'b00; req_unsigned = 0;
    req_addr = 32'h10; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort in rmw addr", mem_address, 32'd4);
    reset = 1'b0;
    #1;
    chk("abort resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort mem_wr", {31'b0, mem_write_read}, 32'd0);
    chk("abort req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort ready after", {31'b0, req_ready}, 32'd1);
    chk("abort no write", writes_total, acc);
    chk("abort mem4", mem[4], 32'h12345AEF);
    lv = tbl[15];
    lv.name = "lw after abort";
    do_req(lv);

    // back-to-back: req_valid held, three loads accepted one per completion
    acc = 0; pulses = 0;
    req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h10;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        pulses++;
        chk("b2b rdata", resp_rdata, 32'h12345AEF);
      end
      if (acc == 3) req_valid = 1'b0;
      else if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b accepts", acc, 3);
    chk("b2b pulses", pulses, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
